// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer
// Runs one matrix-tile pass: pops a weight set from the Weight FIFO, holds the
// systolic weight-reload strobe, streams N activation-row addresses into the
// Unified Buffer, then writes each result row into the Results SRAM PIPE_LAT
// cycles after its address was issued. Every output comes straight from a flop.
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int WRL_CYCLES  = 8,
  parameter int PIPE_LAT    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // One counter serves both the reload hold and the stream row index, so it
  // must be wide enough for whichever of the two is larger.
  localparam int WRL_W = $clog2(WRL_CYCLES) + 1;
  localparam int CNT_W = (ADDRESSSIZE > WRL_W) ? ADDRESSSIZE : WRL_W;

  localparam logic [CNT_W-1:0]       C_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDRESSSIZE-1:0] A_ONE    = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       WRL_LAST = CNT_W'(WRL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_RELOAD = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Registered state and outputs
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDRESSSIZE-1:0] r_n;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_fre;
  logic                   r_we_rl;
  logic                   r_ub_rd;
  logic                   r_done;
  logic                   r_err;
  logic                   r_busy;
  // Valid delay line: bit j holds ub_rd delayed by j+1 cycles; the top bit is
  // the result write enable itself.
  logic [PIPE_LAT-1:0]    r_dly;

  // Next-state values
  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [ADDRESSSIZE-1:0] w_n_next;
  logic [ADDRESSSIZE-1:0] w_ub_addr_next;
  logic [ADDRESSSIZE-1:0] w_res_addr_next;
  logic                   w_fre_next;
  logic                   w_we_rl_next;
  logic                   w_ub_rd_next;
  logic                   w_done_next;
  logic                   w_err_next;
  logic                   w_busy_next;
  logic [PIPE_LAT-1:0]    w_dly_next;
  logic [PIPE_LAT-1:0]    w_dly_shift;
  logic [CNT_W-1:0]       w_last_row;

  assign w_last_row = CNT_W'(r_n) - C_ONE;

  generate
    if (PIPE_LAT == 1) begin : g_dly_single
      assign w_dly_shift = r_ub_rd;
    end else begin : g_dly_multi
      assign w_dly_shift = {r_dly[PIPE_LAT-2:0], r_ub_rd};
    end
  endgenerate

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they can be registered without adding latency to the reference timeline.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_n_next        = r_n;
    w_ub_addr_next  = r_ub_addr;
    w_res_addr_next = r_res_addr;
    w_fre_next      = 1'b0;
    w_we_rl_next    = 1'b0;
    w_ub_rd_next    = 1'b0;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    w_dly_next      = w_dly_shift;

    // Result address walks forward once per issued write.
    if (r_dly[PIPE_LAT-1]) begin
      w_res_addr_next = r_res_addr + A_ONE;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            w_err_next = 1'b1;
          end else begin
            w_state_next    = S_LOAD_W;
            w_n_next        = num_rows;
            w_ub_addr_next  = ub_base;
            w_res_addr_next = res_base;
            w_cnt_next      = '0;
            w_fre_next      = ~fifo_empty;
          end
        end
      end
      S_LOAD_W: begin
        // The pop happens in the cycle r_fre is high; leave right after it.
        if (r_fre) begin
          w_state_next = S_RELOAD;
          w_we_rl_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_fre_next = ~fifo_empty;
        end
      end
      S_RELOAD: begin
        if (r_cnt == WRL_LAST) begin
          w_state_next = S_STREAM;
          w_ub_rd_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_we_rl_next = 1'b1;
          w_cnt_next   = r_cnt + C_ONE;
        end
      end
      S_STREAM: begin
        if (r_cnt == w_last_row) begin
          w_state_next = S_DRAIN;
        end else begin
          w_ub_rd_next   = 1'b1;
          w_ub_addr_next = r_ub_addr + A_ONE;
          w_cnt_next     = r_cnt + C_ONE;
        end
      end
      S_DRAIN: begin
        // Once nothing remains in flight after this edge, the current write
        // (if any) is the last one.
        if (w_dly_shift == '0) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_fre_next   = 1'b0;
      w_we_rl_next = 1'b0;
      w_ub_rd_next = 1'b0;
      w_done_next  = 1'b0;
      w_err_next   = 1'b0;
      w_dly_next   = '0;
    end

    w_busy_next = (w_state_next != S_IDLE);
  end

  // State, counters, delay line and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_ub_addr  <= '0;
      r_res_addr <= '0;
      r_fre      <= 1'b0;
      r_we_rl    <= 1'b0;
      r_ub_rd    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_dly      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_n        <= w_n_next;
      r_ub_addr  <= w_ub_addr_next;
      r_res_addr <= w_res_addr_next;
      r_fre      <= w_fre_next;
      r_we_rl    <= w_we_rl_next;
      r_ub_rd    <= w_ub_rd_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_busy     <= w_busy_next;
      r_dly      <= w_dly_next;
    end
  end

  assign fifo_read_enable = r_fre;
  assign we_rl            = r_we_rl;
  assign ub_addr          = r_ub_addr;
  assign ub_rd            = r_ub_rd;
  assign res_we           = r_dly[PIPE_LAT-1];
  assign res_addr         = r_res_addr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer: each run drives a start at edge 0,
// records every output for cycles 1..len, then compares each cycle against the
// hand-derived reference timeline of the pass(es) expected in that window.
module tb_tpu_tile_sequencer;

  localparam int AW   = 10;
  localparam int WRL  = 8;
  localparam int PL   = 16;
  localparam int NCAP = 80;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [AW-1:0] ub_base;
  logic [AW-1:0] res_base;
  logic [AW-1:0] num_rows;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          we_rl;
  logic [AW-1:0] ub_addr;
  logic          ub_rd;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .ADDRESSSIZE(AW),
    .WRL_CYCLES (WRL),
    .PIPE_LAT   (PL)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .abort           (abort),
    .ub_base         (ub_base),
    .res_base        (res_base),
    .num_rows        (num_rows),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(fifo_read_enable),
    .we_rl           (we_rl),
    .ub_addr         (ub_addr),
    .ub_rd           (ub_rd),
    .res_we          (res_we),
    .res_addr        (res_addr),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  // Per-cycle stimulus (index = cycle number relative to the start edge)
  logic stim_start [0:NCAP-1];
  logic stim_abort [0:NCAP-1];
  logic stim_rst   [0:NCAP-1];
  logic stim_empty [0:NCAP-1];

  // Captured outputs
  logic          cap_fre      [0:NCAP-1];
  logic          cap_we_rl    [0:NCAP-1];
  logic          cap_ub_rd    [0:NCAP-1];
  logic [AW-1:0] cap_ub_addr  [0:NCAP-1];
  logic          cap_res_we   [0:NCAP-1];
  logic [AW-1:0] cap_res_addr [0:NCAP-1];
  logic          cap_busy     [0:NCAP-1];
  logic          cap_done     [0:NCAP-1];
  logic          cap_err      [0:NCAP-1];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp_v);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NCAP; i++) begin
      stim_start[i] = 1'b0;
      stim_abort[i] = 1'b0;
      stim_rst[i]   = 1'b0;
      stim_empty[i] = 1'b0;
    end
  endtask

  // Start at edge 0 with the given config, then run cycles 1..len applying the
  // stimulus tables. Non-start cycles carry junk config to show it is ignored.
  task automatic run_pass(input int len, input logic [AW-1:0] cfg_ub,
                          input logic [AW-1:0] cfg_rb, input logic [AW-1:0] cfg_n);
    @(posedge clk);
    #1;
    start      = 1'b1;
    abort      = 1'b0;
    fifo_empty = stim_empty[0];
    ub_base    = cfg_ub;
    res_base   = cfg_rb;
    num_rows   = cfg_n;
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      #1;
      start      = stim_start[c];
      abort      = stim_abort[c];
      rstn       = !stim_rst[c];
      fifo_empty = stim_empty[c];
      if (stim_start[c]) begin
        ub_base  = cfg_ub;
        res_base = cfg_rb;
        num_rows = cfg_n;
      end else begin
        ub_base  = 10'h155;
        res_base = 10'h2AA;
        num_rows = 10'h000;
      end
      #1;
      cap_fre[c]      = fifo_read_enable;
      cap_we_rl[c]    = we_rl;
      cap_ub_rd[c]    = ub_rd;
      cap_ub_addr[c]  = ub_addr;
      cap_res_we[c]   = res_we;
      cap_res_addr[c] = res_addr;
      cap_busy[c]     = busy;
      cap_done[c]     = done;
      cap_err[c]      = err;
      @(posedge clk);
    end
    #1;
    start      = 1'b0;
    abort      = 1'b0;
    rstn       = 1'b1;
    fifo_empty = 1'b0;
  endtask

  // Compare captured cycles lo..hi against a pass started at edge s that
  // stalled e cycles on an empty FIFO. s far in the future means "idle".
  task automatic check_window(input int lo, input int hi, input int s, input int e,
                              input int n, input logic [AW-1:0] ub, input logic [AW-1:0] rb,
                              input int err_cyc);
    int pop;
    int wl0;
    int st0;
    int rw0;
    int dn;
    logic [AW-1:0] a;
    pop = s + 1 + e;
    wl0 = pop + 1;
    st0 = wl0 + WRL;
    rw0 = st0 + PL;
    dn  = rw0 + n;
    for (int c = lo; c <= hi; c++) begin
      chk("fifo_read_enable", c, 32'(cap_fre[c]),    32'(c == pop));
      chk("we_rl",            c, 32'(cap_we_rl[c]),  32'(c >= wl0 && c < wl0 + WRL));
      chk("ub_rd",            c, 32'(cap_ub_rd[c]),  32'(c >= st0 && c < st0 + n));
      chk("res_we",           c, 32'(cap_res_we[c]), 32'(c >= rw0 && c < rw0 + n));
      chk("done",             c, 32'(cap_done[c]),   32'(c == dn));
      chk("busy",             c, 32'(cap_busy[c]),   32'(c > s && c <= dn));
      chk("err",              c, 32'(cap_err[c]),    32'(c == err_cyc));
      if (c >= st0 && c < st0 + n) begin
        a = ub + AW'(c - st0);
        chk("ub_addr", c, 32'(cap_ub_addr[c]), 32'(a));
      end
      if (c >= rw0 && c < rw0 + n) begin
        a = rb + AW'(c - rw0);
        chk("res_addr", c, 32'(cap_res_addr[c]), 32'(a));
      end
    end
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    fifo_empty = 1'b0;
    ub_base    = '0;
    res_base   = '0;
    num_rows   = '0;
    clear_stim();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fifo_read_enable", 0, 32'(fifo_read_enable), 32'd0);
    chk("reset_we_rl",            0, 32'(we_rl),            32'd0);
    chk("reset_ub_rd",            0, 32'(ub_rd),            32'd0);
    chk("reset_ub_addr",          0, 32'(ub_addr),          32'd0);
    chk("reset_res_we",           0, 32'(res_we),           32'd0);
    chk("reset_res_addr",         0, 32'(res_addr),         32'd0);
    chk("reset_busy",             0, 32'(busy),             32'd0);
    chk("reset_done",             0, 32'(done),             32'd0);
    chk("reset_err",              0, 32'(err),              32'd0);
    rstn = 1'b1;
    $display("reset state checked");

    // Basic pass N=8, with an ignored start during STREAM and a back-to-back
    // start in the cycle right after done.
    clear_stim();
    stim_start[12] = 1'b1;
    stim_start[35] = 1'b1;
    run_pass(70, 10'h010, 10'h100, 10'd8);
    check_window(1, 35, 0, 0, 8, 10'h010, 10'h100, -1);
    check_window(36, 70, 35, 0, 8, 10'h010, 10'h100, -1);
    $display("pass N=8 + ignored start + back-to-back checked");

    // FIFO empty for the first five decision edges
    clear_stim();
    for (int i = 0; i < 5; i++) stim_empty[i] = 1'b1;
    run_pass(40, 10'h010, 10'h100, 10'd8);
    check_window(1, 40, 0, 5, 8, 10'h010, 10'h100, -1);
    $display("fifo stall pass checked");

    // Address wrap-around
    clear_stim();
    run_pass(32, 10'h3FE, 10'h3FF, 10'd4);
    check_window(1, 32, 0, 0, 4, 10'h3FE, 10'h3FF, -1);
    $display("wrap pass checked");

    // N=0 start is rejected
    clear_stim();
    run_pass(4, 10'h010, 10'h100, 10'd0);
    check_window(1, 4, 1000, 0, 0, 10'h010, 10'h100, 1);
    $display("zero-row start checked");

    // Abort in STREAM, abort+start dropped, then clean restart
    clear_stim();
    stim_abort[12] = 1'b1;
    stim_abort[13] = 1'b1;
    stim_start[13] = 1'b1;
    stim_start[14] = 1'b1;
    run_pass(50, 10'h010, 10'h100, 10'd8);
    check_window(1, 12, 0, 0, 8, 10'h010, 10'h100, -1);
    check_window(13, 14, 1000, 0, 8, 10'h010, 10'h100, -1);
    check_window(15, 50, 14, 0, 8, 10'h010, 10'h100, -1);
    $display("abort + restart checked");

    // Reset mid-write, then a fresh pass
    clear_stim();
    stim_rst[28]   = 1'b1;
    stim_start[31] = 1'b1;
    run_pass(66, 10'h010, 10'h100, 10'd8);
    check_window(1, 27, 0, 0, 8, 10'h010, 10'h100, -1);
    check_window(28, 31, 1000, 0, 8, 10'h010, 10'h100, -1);
    check_window(32, 66, 31, 0, 8, 10'h010, 10'h100, -1);
    $display("mid-pass reset + restart checked");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tpu_tile_sequencer.md
# tpu_tile_sequencer

Sequences one matrix-tile pass through the TPU datapath. It pops one weight set from the Weight FIFO and holds the systolic array's weight-reload strobe. It then streams activation-row addresses into the Unified Buffer and writes the aligned results into the Results SRAM. It sits between the host-side start/config registers and the UB, FIFO, systolic array and result SRAM, and replaces the free-running counters currently used for result capture.

## Interface
Parameters:
- ADDRESSSIZE, 10: UB and Results SRAM address width.
- WRL_CYCLES, 8: cycles `we_rl` is held high per weight load; must be ≥ 1.
- PIPE_LAT, 16: cycles from a UB address issue to its result row being valid at the array output. This covers SRAM read, data skew, array traversal and deskew. Must be ≥ 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request; sampled only in IDLE.
- abort, input, 1: synchronous cancel; highest priority in every state.
- ub_base, input, ADDRESSSIZE: first UB row address; captured on accepted start.
- res_base, input, ADDRESSSIZE: first result row address; captured on accepted start.
- num_rows, input, ADDRESSSIZE: number of activation rows N, 1..2^ADDRESSSIZE-1; captured on start.
- fifo_empty, input, 1: Weight FIFO empty flag.
- fifo_read_enable, output, 1: one-cycle FIFO pop.
- we_rl, output, 1: systolic weight reload.
- ub_addr, output, ADDRESSSIZE: UB read address.
- ub_rd, output, 1: `ub_addr` is valid this cycle.
- res_we, output, 1: Results SRAM write enable.
- res_addr, output, ADDRESSSIZE: Results SRAM write address.
- busy, output, 1: state ≠ IDLE.
- done, output, 1: one-cycle pulse at end of pass.
- err, output, 1: one-cycle pulse when start is rejected.

## Operation
- States and transitions:
  - IDLE:
    - start with N≠0 → LOAD_W.
    - start with N=0 → pulse `err`, stay in IDLE.
  - LOAD_W:
    - While `fifo_empty`, wait with `fifo_read_enable`=0.
    - When not empty, assert `fifo_read_enable` for exactly one cycle → RELOAD.
  - RELOAD: `we_rl`=1 for exactly WRL_CYCLES cycles → STREAM.
  - STREAM:
    - Cycle k (k=0..N-1): `ub_rd`=1 and `ub_addr` = (ub_base + k) mod 2^ADDRESSSIZE.
    - After k=N-1 → DRAIN.
  - DRAIN: wait until the last result write has issued → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Result alignment:
  - An issue at STREAM cycle k produces `res_we`=1 exactly PIPE_LAT cycles later.
  - At that write, `res_addr` = (res_base + k) mod 2^ADDRESSSIZE.
  - Implemented as a PIPE_LAT-deep valid delay line plus a result-address counter that advances on each `res_we`.
- Address arithmetic: modulo 2^ADDRESSSIZE; wrap-around is legal and silent.
- `start` while busy is ignored. No `err` is raised and the in-flight pass is unaffected.
- `abort`:
  - Next cycle the FSM is in IDLE and the delay line is cleared.
  - `we_rl`, `ub_rd`, `res_we` and `fifo_read_enable` are 0 from that cycle on.
  - No `done` pulse is produced.
  - A weight set already popped is not restored.
- `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
- Config inputs are ignored outside the accepting start cycle.

## Timing
- Reset values: all outputs 0, FSM in IDLE, delay line cleared, all counters 0.
- Reset mid-pass: outputs drop to 0 asynchronously. No further FIFO pop or SRAM write occurs.
- Every output is registered (driven from flops, not combinational logic).
- Reference timeline, start accepted at edge 0 with the FIFO non-empty:
  - Cycle 1: `fifo_read_enable`=1.
  - Cycles 2..1+WRL_CYCLES: `we_rl`=1.
  - STREAM occupies cycles S..S+N-1, where S = 2+WRL_CYCLES.
  - `res_we` is high in cycles S+PIPE_LAT .. S+PIPE_LAT+N-1.
  - `done` is high in cycle S+PIPE_LAT+N.
  - `busy` is high in cycles 1 .. S+PIPE_LAT+N.
- Each cycle LOAD_W stalls on `fifo_empty` shifts every later event by one cycle.
- Back-to-back passes: a start in the cycle immediately after `done` is accepted.

## Test plan
- N=8, ub_base=0x010, res_base=0x100, defaults, FIFO non-empty:
  - One pop at cycle 1.
  - `we_rl` high at cycles 2–9.
  - `ub_addr` 0x010..0x017 at cycles 10–17.
  - `res_we` at cycles 26–33 with `res_addr` 0x100..0x107.
  - `done` at cycle 34 and nowhere else.
- FIFO empty for 5 cycles after start: `fifo_read_enable` stays 0, then pops once at cycle 6. All later events shift by +5 and `done` is at cycle 39.
- N=4, ub_base=0x3FE, res_base=0x3FF:
  - `ub_addr` sequence is 0x3FE, 0x3FF, 0x000, 0x001.
  - `res_addr` sequence is 0x3FF, 0x000, 0x001, 0x002.
- Error and ignored start:
  - start with N=0: `err` pulses at cycle 1, `busy` stays 0, no pop.
  - start asserted during STREAM: ignored, and the timeline matches test 1.
- abort at cycle 12 of test 1:
  - From cycle 13 all strobes are 0 and `busy` is 0.
  - No `res_we` and no `done` occur; the delay line is empty.
  - A new start at cycle 14 runs a clean pass.
- rstn low at cycle 28 of test 1:
  - `res_we` falls immediately with no further writes.
  - After release, a start gives the exact test-1 timeline.
